ines_stream_loader: RTL and testbench
=====================================

Name: ines_stream_loader

Overview:
- Consumes the ROM byte stream produced by the SD menu loader (one byte per `din_valid` pulse, no backpressure).
- Parses the 16-byte iNES header and skips the optional 512-byte trainer.
- Turns PRG and CHR payload bytes into addressed memory-write requests, with a small FIFO between the unthrottled stream and the acknowledged memory port.
- Sits between the SD loader and the SDRAM/BRAM controller; its header fields configure the NES mapper.

Parameters:
- FIFO_DEPTH, 4, entries of {addr,data} buffered toward memory; power of two, at least 2.
- ADDR_W, 22, width of `mem_addr`.
- PRG_BASE, 0, memory address of the first PRG byte.
- CHR_BASE, 22'h200000, memory address of the first CHR byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a new image, reparse header
- din  in  8  stream byte
- din_valid  in  1  one-cycle pulse, `din` valid
- mem_addr  out  ADDR_W  write address
- mem_data  out  8  write data
- mem_we  out  1  write request, held until acked
- mem_ack  in  1  memory accepted current write
- hdr_valid  out  1  header parsed and accepted
- mapper  out  8  {flags7[7:4], flags6[7:4]}
- prg_banks  out  8  16 KB PRG units
- chr_banks  out  8  8 KB CHR units
- mirroring  out  1  flags6[0]
- has_battery  out  1  flags6[1]
- busy  out  1  state is not IDLE/DONE/ERR, or FIFO non-empty
- done  out  1  payload complete and FIFO drained
- error  out  1  sticky error
- err_code  out  2  0 none, 1 bad magic, 2 zero PRG, 3 FIFO overflow

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0.
- `start` forces state HEADER from any state. It clears hdr_valid, done, error, err_code, header fields, counters and FIFO. A `din_valid` in the same cycle is discarded.
- States: IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERR. Bytes in IDLE, DONE and ERR are ignored.
- HEADER: 4-bit index counts bytes 0..15.
  - Bytes 0..3 must be 4E 45 53 1A; a mismatch on the offending byte -> ERR, code 1.
  - Byte 4 -> prg_banks; byte 5 -> chr_banks; byte 6 -> mirroring, has_battery, trainer flag (bit2), mapper[3:0]; byte 7[7:4] -> mapper[7:4]; bytes 8..15 ignored.
  - On byte 15: if prg_banks==0 -> ERR, code 2. Otherwise hdr_valid=1 the next cycle, then go to TRAINER if trainer flag else PRG.
- TRAINER: discard exactly 512 bytes, then PRG.
- PRG: 22-bit offset counter.
  - Each byte pushes {PRG_BASE+offset, din}.
  - After byte prg_banks*16384-1: go to CHR if chr_banks!=0, else DONE.
- CHR: same scheme, CHR_BASE+offset, length chr_banks*8192, then DONE.
- Address arithmetic is modulo 2^ADDR_W.
- Extra bytes after DONE are ignored with no error.
- FIFO / memory port:
  - `mem_we` = FIFO non-empty; `mem_addr`/`mem_data` = head entry, registered.
  - A byte accepted in cycle N with FIFO empty shows `mem_we`=1 in cycle N+1.
  - `mem_ack` while `mem_we`=1 pops the head; the next entry is presented the following cycle (or `mem_we` drops).
  - `mem_ack` while `mem_we`=0 is ignored.
  - Push and pop in the same cycle when full: legal, no overflow.
  - Push when full with no pop -> byte dropped, ERR, code 3.
- ERR: error=1 and FIFO is flushed (`mem_we`=0 next cycle). State is held until `start` or reset.
- done=1 only in DONE with FIFO empty; held until `start`/reset.
- Reset mid-transfer: everything returns to reset values immediately; a pending write is abandoned.

Test Plan:
- Valid image 4E 45 53 1A 02 01 01 00 + 8 zeros, then 32768 PRG + 8192 CHR bytes, ack every cycle.
  - hdr_valid=1, prg_banks=2, chr_banks=1, mirroring=1, mapper=0.
  - First write addr 0; last PRG addr 0x7FFF; first CHR addr 0x200000; last CHR addr 0x201FFF.
  - Exactly 40960 writes, then done=1.
- Bad magic: byte 2 = 0x54 -> error=1, err_code=1, no mem_we ever; then `start` + valid image -> normal completion.
- Flags6=0x14, flags7=0x40, 1 PRG bank, 0 CHR, trainer present.
  - mapper=0x41, has_battery=0.
  - The 512 trainer bytes produce no writes; 16384 writes at 0..0x3FFF, then done.
- Backpressure: hold mem_ack low with FIFO_DEPTH=4.
  - Payload bytes 1-4 are buffered; byte 5 -> err_code=3, mem_we=0 next cycle.
  - Repeat with ack every 2nd cycle and din every 3rd cycle -> no error, addresses strictly sequential.
- Header with prg_banks=0 -> err_code=2 after byte 15; hdr_valid stays 0.
- Async reset asserted mid-PRG (FIFO holding 2 entries) -> mem_we, busy, hdr_valid all 0 immediately, no further writes; `start` after release -> normal load.

Source files
------------

// File: rtl/ines_stream_loader.sv
// iNES image stream loader: parses the 16-byte header, skips the optional trainer,
// and turns PRG/CHR payload bytes into addressed writes through a small FIFO.
module ines_stream_loader #(
    parameter int               FIFO_DEPTH = 4,
    parameter int               ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] PRG_BASE  = '0,
    parameter logic [ADDR_W-1:0] CHR_BASE  = ADDR_W'(22'h200000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              hdr_valid,
    output logic [7:0]        mapper,
    output logic [7:0]        prg_banks,
    output logic [7:0]        chr_banks,
    output logic              mirroring,
    output logic              has_battery,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = 22;
    localparam int ENT_W = ADDR_W + 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_TRAINER,
        S_PRG,
        S_CHR,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         hdr_idx_q, hdr_idx_d;
    logic [8:0]         trn_cnt_q, trn_cnt_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [7:0]         prg_banks_q, prg_banks_d;
    logic [7:0]         chr_banks_q, chr_banks_d;
    logic [7:0]         mapper_q, mapper_d;
    logic               mirroring_q, mirroring_d;
    logic               has_battery_q, has_battery_d;
    logic               trainer_q, trainer_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               flush;
    logic [ENT_W-1:0]   push_ent;
    logic [ENT_W-1:0]   head;
    logic [OFF_W-1:0]   prg_last;
    logic [OFF_W-1:0]   chr_last;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h4E;
            2'd1:    return 8'h45;
            2'd2:    return 8'h53;
            default: return 8'h1A;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base,
                                                  input logic [OFF_W-1:0]  off);
        return base + ADDR_W'(off);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = mem_ack && !fifo_empty;
    assign head       = fifo_q[rd_ptr_q];

    // Region lengths are bank counts shifted into bytes; offsets compare against the last byte.
    assign prg_last = {prg_banks_q, 14'd0} - 22'd1;
    assign chr_last = {1'b0, chr_banks_q, 13'd0} - 22'd1;

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        trn_cnt_d     = trn_cnt_q;
        off_d         = off_q;
        prg_banks_d   = prg_banks_q;
        chr_banks_d   = chr_banks_q;
        mapper_d      = mapper_q;
        mirroring_d   = mirroring_q;
        has_battery_d = has_battery_q;
        trainer_d     = trainer_q;
        hdr_valid_d   = hdr_valid_q;
        err_code_d    = err_code_q;
        push          = 1'b0;
        push_ent      = '0;

        if (start) begin
            state_d       = S_HEADER;
            hdr_idx_d     = '0;
            trn_cnt_d     = '0;
            off_d         = '0;
            prg_banks_d   = '0;
            chr_banks_d   = '0;
            mapper_d      = '0;
            mirroring_d   = 1'b0;
            has_battery_d = 1'b0;
            trainer_d     = 1'b0;
            hdr_valid_d   = 1'b0;
            err_code_d    = 2'd0;
        end else begin
            if (din_valid) begin
                case (state_q)
                    S_HEADER: begin
                        hdr_idx_d = hdr_idx_q + 4'd1;
                        case (hdr_idx_q)
                            4'd0, 4'd1, 4'd2, 4'd3: begin
                                if (din != magic_byte(hdr_idx_q[1:0])) begin
                                    state_d    = S_ERR;
                                    err_code_d = 2'd1;
                                end
                            end
                            4'd4: prg_banks_d = din;
                            4'd5: chr_banks_d = din;
                            4'd6: begin
                                mirroring_d   = din[0];
                                has_battery_d = din[1];
                                trainer_d     = din[2];
                                mapper_d[3:0] = din[7:4];
                            end
                            4'd7: mapper_d[7:4] = din[7:4];
                            4'd15: begin
                                if (prg_banks_q == 8'd0) begin
                                    state_d    = S_ERR;
                                    err_code_d = 2'd2;
                                end else begin
                                    hdr_valid_d = 1'b1;
                                    state_d     = trainer_q ? S_TRAINER : S_PRG;
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_TRAINER: begin
                        trn_cnt_d = trn_cnt_q + 9'd1;
                        if (trn_cnt_q == 9'd511) begin
                            state_d = S_PRG;
                        end
                    end
                    S_PRG: begin
                        push     = 1'b1;
                        push_ent = {addr_of(PRG_BASE, off_q), din};
                        off_d    = off_q + 22'd1;
                        if (off_q == prg_last) begin
                            off_d   = '0;
                            state_d = (chr_banks_q != 8'd0) ? S_CHR : S_DONE;
                        end
                    end
                    S_CHR: begin
                        push     = 1'b1;
                        push_ent = {addr_of(CHR_BASE, off_q), din};
                        off_d    = off_q + 22'd1;
                        if (off_q == chr_last) begin
                            off_d   = '0;
                            state_d = S_DONE;
                        end
                    end
                    default: ;
                endcase
            end

            // A full FIFO only overflows when the head is not leaving in the same cycle.
            if (push && fifo_full && !pop) begin
                push       = 1'b0;
                state_d    = S_ERR;
                err_code_d = 2'd3;
            end
        end
    end

    assign flush = start || (state_d == S_ERR);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            hdr_idx_q     <= '0;
            trn_cnt_q     <= '0;
            off_q         <= '0;
            prg_banks_q   <= '0;
            chr_banks_q   <= '0;
            mapper_q      <= '0;
            mirroring_q   <= 1'b0;
            has_battery_q <= 1'b0;
            trainer_q     <= 1'b0;
            hdr_valid_q   <= 1'b0;
            err_code_q    <= 2'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            hdr_idx_q     <= hdr_idx_d;
            trn_cnt_q     <= trn_cnt_d;
            off_q         <= off_d;
            prg_banks_q   <= prg_banks_d;
            chr_banks_q   <= chr_banks_d;
            mapper_q      <= mapper_d;
            mirroring_q   <= mirroring_d;
            has_battery_q <= has_battery_d;
            trainer_q     <= trainer_d;
            hdr_valid_q   <= hdr_valid_d;
            err_code_q    <= err_code_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Entry storage carries no reset; the port outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_q[wr_ptr_q] <= push_ent;
        end
    end

    assign mem_we      = !fifo_empty;
    assign mem_addr    = fifo_empty ? '0 : head[ENT_W-1:8];
    assign mem_data    = fifo_empty ? '0 : head[7:0];
    assign hdr_valid   = hdr_valid_q;
    assign mapper      = mapper_q;
    assign prg_banks   = prg_banks_q;
    assign chr_banks   = chr_banks_q;
    assign mirroring   = mirroring_q;
    assign has_battery = has_battery_q;
    assign error       = (state_q == S_ERR);
    assign err_code    = err_code_q;
    assign done        = (state_q == S_DONE) && fifo_empty;
    assign busy        = !fifo_empty ||
                         !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

endmodule

// File: tb/tb_ines_stream_loader.sv
// Directed bench for ines_stream_loader: header decode table plus multi-cycle load,
// overflow, backpressure and reset sequences, with a write scoreboard.
module tb_ines_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  din;
    logic        din_valid;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic        hdr_valid;
    logic [7:0]  mapper;
    logic [7:0]  prg_banks;
    logic [7:0]  chr_banks;
    logic        mirroring;
    logic        has_battery;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    ines_stream_loader dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
        .hdr_valid(hdr_valid), .mapper(mapper), .prg_banks(prg_banks),
        .chr_banks(chr_banks), .mirroring(mirroring), .has_battery(has_battery),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_mode = 1;          // 0 never, 1 every cycle, 2 every second cycle
    logic mon_chk = 1'b1;

    logic [29:0] exp_mem [0:65535];
    int exp_wr = 0;
    int exp_rd = 0;
    int wr_count = 0;
    int wr_bad = 0;

    // Write scoreboard: an accepted write is mem_we && mem_ack at the falling edge.
    always @(negedge clk) begin
        if (reset || !mon_chk) begin
            exp_rd <= exp_wr;
        end else if (mem_we && mem_ack) begin
            wr_count <= wr_count + 1;
            if (exp_rd == exp_wr) begin
                wr_bad <= wr_bad + 1;
            end else begin
                if (exp_mem[exp_rd[15:0]] != {mem_addr, mem_data}) wr_bad <= wr_bad + 1;
                exp_rd <= exp_rd + 1;
            end
        end
    end

    typedef struct {
        logic [7:0] m2, prg, chr, f6, f7;
        logic [7:0] e_map, e_prg, e_chr;
        logic       e_mir, e_bat, e_hv, e_busy;
        logic [1:0] e_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ack_mode)
            0:       mem_ack = 1'b0;
            1:       mem_ack = 1'b1;
            default: mem_ack = cyc[0];
        endcase
    endtask

    task automatic send(input logic [7:0] b);
        din = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [7:0] hdr_byte(input int idx, input logic [7:0] m2, prg, chr, f6, f7);
        case (idx)
            0: return 8'h4E;
            1: return 8'h45;
            2: return m2;
            3: return 8'h1A;
            4: return prg;
            5: return chr;
            6: return f6;
            7: return f7;
            default: return 8'h00;
        endcase
    endfunction

    task automatic send_hdr(input logic [7:0] prg, chr, f6, f7);
        for (int b = 0; b < 16; b++) send(hdr_byte(b, 8'h53, prg, chr, f6, f7));
    endtask

    function automatic logic [7:0] pdata(input int i);
        return 8'((i * 13) + 7);
    endfunction

    task automatic push_exp(input logic [21:0] a, input logic [7:0] d);
        if (mon_chk) begin
            exp_mem[exp_wr[15:0]] = {a, d};
            exp_wr++;
        end
    endtask

    task automatic send_payload(input int n, input logic [21:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            push_exp(22'(base + 22'(i)), pdata(i));
            send(pdata(i));
            repeat (gap) tick();
        end
    endtask

    initial begin
        int base_wr;
        int base_bad;

        vecs[0] = '{8'h53, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h01, 1, 0, 1, 1, 2'd0};
        vecs[1] = '{8'h53, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 2'd2};
        vecs[2] = '{8'h53, 8'h01, 8'h00, 8'h14, 8'h40, 8'h41, 8'h01, 8'h00, 0, 0, 1, 1, 2'd0};
        vecs[3] = '{8'h53, 8'h10, 8'h20, 8'hF3, 8'hA0, 8'hAF, 8'h10, 8'h20, 1, 1, 1, 1, 2'd0};
        vecs[4] = '{8'h54, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 2'd1};
        vecs[5] = '{8'h53, 8'hFF, 8'hFF, 8'h02, 8'hF0, 8'hF0, 8'hFF, 8'hFF, 0, 1, 1, 1, 2'd0};

        reset = 1'b1; start = 1'b0; din = 8'h00; din_valid = 1'b0; mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_hdr_valid", 32'(hdr_valid), 0);
        chk("rst_outputs", 32'({mapper, prg_banks, chr_banks, err_code, mirroring, has_battery}), 0);
        reset = 1'b0;
        tick();

        // Header decode table
        for (int v = 0; v < 6; v++) begin
            pulse_start();
            for (int b = 0; b < 16; b++) begin
                send(hdr_byte(b, vecs[v].m2, vecs[v].prg, vecs[v].chr, vecs[v].f6, vecs[v].f7));
                if (b == 14) chk($sformatf("v%0d_hv_early", v), 32'(hdr_valid), 0);
            end
            chk($sformatf("v%0d_hdr_valid", v), 32'(hdr_valid), 32'(vecs[v].e_hv));
            chk($sformatf("v%0d_err_code", v), 32'(err_code), 32'(vecs[v].e_err));
            chk($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].e_err != 2'd0));
            chk($sformatf("v%0d_mapper", v), 32'(mapper), 32'(vecs[v].e_map));
            chk($sformatf("v%0d_banks", v), 32'({prg_banks, chr_banks}), 32'({vecs[v].e_prg, vecs[v].e_chr}));
            chk($sformatf("v%0d_flags", v), 32'({mirroring, has_battery}), 32'({vecs[v].e_mir, vecs[v].e_bat}));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
            chk($sformatf("v%0d_mem_we", v), 32'(mem_we), 0);
        end

        // Full image: 2 PRG banks, 1 CHR bank, ack every cycle
        ack_mode = 1;
        base_wr = wr_count; base_bad = wr_bad;
        pulse_start();
        send_hdr(8'h02, 8'h01, 8'h01, 8'h00);
        chk("img_hdr_valid", 32'(hdr_valid), 1);
        chk("img_busy", 32'(busy), 1);
        for (int i = 0; i < 32768; i++) begin
            push_exp(22'(i), pdata(i));
            send(pdata(i));
            if (i == 0) chk("img_first_we_addr", 32'({mem_we, mem_addr}), 32'({1'b1, 22'h000000}));
            if (i == 32767) chk("img_last_prg_addr", 32'(mem_addr), 32'h7FFF);
        end
        for (int i = 0; i < 8192; i++) begin
            push_exp(22'(22'h200000 + 22'(i)), pdata(i));
            send(pdata(i));
            if (i == 0) chk("img_first_chr_addr", 32'(mem_addr), 32'h200000);
            if (i == 8191) chk("img_last_chr_addr", 32'(mem_addr), 32'h201FFF);
        end
        repeat (4) tick();
        chk("img_writes", 32'(wr_count - base_wr), 40960);
        chk("img_wr_seq", 32'(wr_bad - base_bad), 0);
        chk("img_pending", 32'(exp_wr - exp_rd), 0);
        chk("img_done", 32'(done), 1);
        chk("img_busy_end", 32'(busy), 0);
        send(8'hAA);
        repeat (2) tick();
        chk("img_extra_ignored", 32'({done, error, mem_we}), 32'(3'b100));

        // Bad magic, then restart with a trainer image
        base_wr = wr_count; base_bad = wr_bad;
        pulse_start();
        for (int b = 0; b < 16; b++) begin
            send(hdr_byte(b, 8'h54, 8'h02, 8'h01, 8'h01, 8'h00));
            if (b == 2) chk("bad_magic_err", 32'({error, err_code}), 32'(3'b101));
        end
        repeat (3) tick();
        chk("bad_magic_nowrite", 32'(wr_count - base_wr), 0);
        chk("bad_magic_hv", 32'(hdr_valid), 0);
        pulse_start();
        chk("restart_cleared", 32'({error, err_code}), 0);
        send_hdr(8'h01, 8'h00, 8'h14, 8'h40);
        chk("trn_mapper", 32'(mapper), 32'h41);
        chk("trn_battery", 32'(has_battery), 0);
        for (int i = 0; i < 512; i++) send(8'hEE);
        tick();
        chk("trn_no_writes", 32'(wr_count - base_wr), 0);
        chk("trn_mem_we", 32'(mem_we), 0);
        send_payload(16384, 22'h000000, 0);
        repeat (4) tick();
        chk("trn_writes", 32'(wr_count - base_wr), 16384);
        chk("trn_wr_seq", 32'(wr_bad - base_bad), 0);
        chk("trn_done", 32'(done), 1);

        // Overflow with ack held low
        mon_chk = 1'b0;
        pulse_start();
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        ack_mode = 0;
        tick();
        for (int i = 0; i < 4; i++) send(pdata(i));
        chk("ovf_buffered", 32'({mem_we, error, busy}), 32'(3'b101));
        chk("ovf_head", 32'({mem_addr, mem_data}), 32'({22'h000000, pdata(0)}));
        send(pdata(4));
        chk("ovf_err", 32'({error, err_code}), 32'(3'b111));
        chk("ovf_flushed", 32'(mem_we), 0);
        repeat (3) tick();
        chk("ovf_held", 32'({error, mem_we, busy}), 32'(3'b100));

        // Ack every second cycle, data every third cycle
        mon_chk = 1'b1;
        tick();
        base_wr = wr_count; base_bad = wr_bad;
        pulse_start();
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        ack_mode = 2;
        send_payload(600, 22'h000000, 2);
        repeat (10) tick();
        chk("bp_error", 32'(error), 0);
        chk("bp_writes", 32'(wr_count - base_wr), 600);
        chk("bp_wr_seq", 32'(wr_bad - base_bad), 0);
        chk("bp_pending", 32'(exp_wr - exp_rd), 0);

        // Async reset with two entries pending
        mon_chk = 1'b0;
        ack_mode = 0;
        pulse_start();
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        send(pdata(0));
        send(pdata(1));
        chk("pre_rst_state", 32'({mem_we, busy, hdr_valid}), 32'(3'b111));
        #3 reset = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({mem_we, busy, hdr_valid}), 0);
        tick();
        tick();
        reset = 1'b0;
        mon_chk = 1'b1;
        ack_mode = 1;
        base_wr = wr_count; base_bad = wr_bad;
        repeat (5) tick();
        chk("post_rst_idle", 32'({mem_we, busy, done, error}), 0);
        chk("post_rst_nowrite", 32'(wr_count - base_wr), 0);
        pulse_start();
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        send_payload(16384, 22'h000000, 0);
        repeat (4) tick();
        chk("rl_writes", 32'(wr_count - base_wr), 16384);
        chk("rl_wr_seq", 32'(wr_bad - base_bad), 0);
        chk("rl_done", 32'({done, error}), 32'(2'b10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
